seq_lock_ctrl: RTL and testbench

//  Parametrised sequentially-locked controller: the next generation of our benchmark-class FSM controllers.

---
 rtl/seq_lock_pkg.sv | 44 ++++
 rtl/seq_lock_ctrl_lfsr.sv | 27 ++
 rtl/seq_lock_ctrl.sv | 102 ++++++++++
 tb/tb_seq_lock_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seq_lock_pkg.sv
// Shared types and helpers for the sequentially-locked controller:
// FSM state encoding, LFSR tap table and key-word extraction.
package seq_lock_pkg;

    typedef enum logic [1:0] {
        AUTH = 2'd0,
        FUNC = 2'd1,
        TRAP = 2'd2
    } state_t;

    localparam int MAX_KEY_BITS = 256;
    localparam int MAX_WORD_W   = 32;

    // Maximal-length Fibonacci taps, bit i set means stage i+1 feeds back.
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            default: return 32'h0000_0060;
        endcase
    endfunction

    // Word idx of a packed key; word 0 sits in the LSBs.
    function automatic logic [MAX_WORD_W-1:0] key_word(input logic [MAX_KEY_BITS-1:0] seq,
                                                       input int idx, input int w);
        logic [MAX_KEY_BITS-1:0] sh;
        sh = seq >> (idx * w);
        return sh[MAX_WORD_W-1:0] & ((MAX_WORD_W'(1) << w) - MAX_WORD_W'(1));
    endfunction

endpackage

// File: rtl/seq_lock_ctrl_lfsr.sv
// Fibonacci LFSR used to corrupt the outputs once the controller has trapped.
module lock_lfsr
    import seq_lock_pkg::*;
#(
    parameter int           W    = 7,
    parameter logic [W-1:0] SEED = W'(1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic fb;
    assign fb = ^(q & TAPS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[W-2:0], fb};
        end
    end

endmodule

// File: rtl/seq_lock_ctrl.sv
// Key-locked counter controller: a KEY_LEN-word key unlocks the counter core,
// any wrong word traps it and XORs an LFSR stream onto the outputs until reset.
module seq_lock_ctrl
    import seq_lock_pkg::*;
#(
    parameter int                      IN_W      = 7,
    parameter int                      OUT_W     = 7,
    parameter int                      ST_W      = 6,
    parameter int                      KEY_LEN   = 4,
    parameter logic [KEY_LEN*IN_W-1:0] KEY_SEQ   = {7'h4C, 7'h33, 7'h2A, 7'h15},
    parameter logic [OUT_W-1:0]        LFSR_SEED = OUT_W'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_bus,
    output logic [OUT_W-1:0] out_bus,
    output logic             unlocked,
    output logic             trapped
);

    localparam int                 IDX_W    = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(KEY_LEN - 1);
    localparam logic [MAX_KEY_BITS-1:0] KEY_EXT = MAX_KEY_BITS'(KEY_SEQ);

    state_t            state, state_next;
    logic [IDX_W-1:0]  key_idx, key_idx_next;
    logic [ST_W-1:0]   cnt, cnt_next;
    logic [OUT_W-1:0]  out_next;
    logic [OUT_W-1:0]  lfsr_q;
    logic [IN_W-1:0]   expected_word;
    logic              clr, en, tc;

    assign clr = in_bus[1];
    assign en  = in_bus[0];
    assign tc  = (cnt == '1) && en;

    assign expected_word = IN_W'(key_word(KEY_EXT, int'(key_idx), IN_W));

    lock_lfsr #(
        .W    (OUT_W),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (state == TRAP),
        .q     (lfsr_q)
    );

    always_comb begin
        // NOTE: every variable gets a default first, so no branch can infer a latch.
        state_next   = state;
        key_idx_next = key_idx;
        cnt_next     = cnt;
        out_next     = '0;

        case (state)
            AUTH: begin
                cnt_next = '0;
                if (in_bus == expected_word) begin
                    if (key_idx == LAST_IDX) begin
                        state_next = FUNC;
                    end else begin
                        key_idx_next = key_idx + 1'b1;
                    end
                end else begin
                    state_next = TRAP;
                end
            end
            FUNC, TRAP: begin
                if (clr) begin
                    cnt_next = '0;
                end else if (en) begin
                    cnt_next = cnt + 1'b1;
                end
                out_next = OUT_W'({tc, cnt});
                if (state == TRAP) begin
                    out_next = out_next ^ lfsr_q;
                end
            end
            default: state_next = AUTH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking so every flop samples the pre-edge values together.
        if (reset) begin
            state   <= AUTH;
            key_idx <= '0;
            cnt     <= '0;
            out_bus <= '0;
        end else begin
            state   <= state_next;
            key_idx <= key_idx_next;
            cnt     <= cnt_next;
            out_bus <= out_next;
        end
    end

    assign unlocked = (state == FUNC);
    assign trapped  = (state == TRAP);

endmodule

// File: tb/tb_seq_lock_ctrl.sv
// Directed bench for seq_lock_ctrl: default 4-word key instance plus a KEY_LEN=1 instance.
module tb_seq_lock_ctrl;

    logic       clk = 1'b0;
    logic       reset, reset1;
    logic [6:0] in_bus, in_bus1;
    logic [6:0] out_bus, out_bus1;
    logic       unlocked, trapped, unlocked1, trapped1;

    int n_tests  = 0;
    int n_failed = 0;

    always #5 clk = ~clk;

    seq_lock_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .in_bus   (in_bus),
        .out_bus  (out_bus),
        .unlocked (unlocked),
        .trapped  (trapped)
    );

    seq_lock_ctrl #(
        .KEY_LEN (1),
        .KEY_SEQ (7'h7F)
    ) dut1 (
        .clk      (clk),
        .reset    (reset1),
        .in_bus   (in_bus1),
        .out_bus  (out_bus1),
        .unlocked (unlocked1),
        .trapped  (trapped1)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [6:0] v);
        in_bus = v;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic [6:0] v);
        in_bus1 = v;
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, check outputs drop at once, then release.
    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_out"}, int'(out_bus), 0);
        check({tag, "_unl"}, int'(unlocked), 0);
        check({tag, "_trp"}, int'(trapped), 0);
        #2;
        reset = 1'b0;
    endtask

    task automatic apply_key();
        step(7'h15);
        step(7'h2A);
        step(7'h33);
        step(7'h4C);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [6:0] trap_seq [8];
        trap_seq = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};

        reset   = 1'b1;
        reset1  = 1'b1;
        in_bus  = '0;
        in_bus1 = '0;
        @(posedge clk);
        #1;
        check("rst_out", int'(out_bus), 0);
        check("rst_unl", int'(unlocked), 0);
        check("rst_trp", int'(trapped), 0);
        check("rst1_out", int'(out_bus1), 0);
        reset = 1'b0;
        #1;
        check("post_rst_out", int'(out_bus), 0);

        // Correct key, then three counting cycles.
        step(7'h15);
        check("key1_unl", int'(unlocked), 0);
        step(7'h2A);
        step(7'h33);
        check("key3_unl", int'(unlocked), 0);
        step(7'h4C);
        check("key4_unl", int'(unlocked), 1);
        check("key4_trp", int'(trapped), 0);
        check("key4_out", int'(out_bus), 0);
        step(7'h01);
        check("cnt_a", int'(out_bus), 'h00);
        step(7'h01);
        check("cnt_b", int'(out_bus), 'h01);
        step(7'h01);
        check("cnt_c", int'(out_bus), 'h02);
        step(7'h00);
        check("cnt_d", int'(out_bus), 'h03);

        // Reset in FUNC, re-unlock, then wrap the counter.
        pulse_reset("rst_func");
        apply_key();
        check("relock_unl", int'(unlocked), 1);
        for (int k = 1; k <= 63; k++) begin
            step(7'h01);
            check("wrap_cnt", int'(out_bus), k - 1);
        end
        step(7'h00);
        check("tc_needs_en", int'(out_bus), 'h3F);
        step(7'h01);
        check("tc_at_3f", int'(out_bus), 'h7F);
        step(7'h01);
        check("wrapped_0", int'(out_bus), 'h00);
        step(7'h01);
        check("after_wrap", int'(out_bus), 'h01);
        step(7'h03);
        check("clr_sample", int'(out_bus), 'h02);
        step(7'h00);
        check("clr_prio", int'(out_bus), 'h00);

        // Reset mid-key: the full key must be re-entered.
        pulse_reset("rst_pre");
        step(7'h15);
        step(7'h2A);
        pulse_reset("rst_midkey");
        apply_key();
        check("midkey_unl", int'(unlocked), 1);
        check("midkey_trp", int'(trapped), 0);

        // Wrong third word traps; outputs carry the LFSR stream.
        pulse_reset("rst_pretrap");
        step(7'h15);
        step(7'h2A);
        step(7'h00);
        check("trap_trp", int'(trapped), 1);
        check("trap_unl", int'(unlocked), 0);
        check("trap_out0", int'(out_bus), 0);
        for (int i = 0; i < 8; i++) begin
            step(7'h00);
            check("trap_lfsr", int'(out_bus), int'(trap_seq[i]));
            check("trap_unl_hold", int'(unlocked), 0);
        end

        // Reset in TRAP; the same wrong sequence traps again from the seed.
        pulse_reset("rst_trap");
        step(7'h15);
        step(7'h2A);
        step(7'h00);
        check("retrap_trp", int'(trapped), 1);
        step(7'h00);
        check("retrap_seed", int'(out_bus), 'h01);

        // Single-word key instance.
        reset1 = 1'b0;
        step1(7'h7F);
        check("k1_unl", int'(unlocked1), 1);
        check("k1_trp", int'(trapped1), 0);
        step1(7'h01);
        step1(7'h00);
        check("k1_cnt", int'(out_bus1), 'h01);
        reset1 = 1'b1;
        #1;
        check("k1_rst_out", int'(out_bus1), 0);
        #2;
        reset1 = 1'b0;
        step1(7'h7E);
        check("k1_bad_trp", int'(trapped1), 1);
        check("k1_bad_unl", int'(unlocked1), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
